cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

- Multi-cycle control unit for the 16-bit accumulator machine.
- Fetches instructions over a single-port memory handshake, decodes them, and drives the op code and operands of the external combinational ALU.
- Owns the PC, IR, AC and operand (MDR) registers, and writes ALU results back to AC.
- Sits between the instruction/data memory and the ALU; it is the only sequencer of the datapath.

## Interface
Parameters:
- AW, 12, address width; PC and instruction address field width
- DW, 16, data/instruction width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write (STA), 0 = read
- mem_addr  out  AW  request address
- mem_wdata  out  DW  write data (AC)
- mem_rdata  in  DW  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  completes the current request; may be asserted in the same cycle as mem_req
- alu_op  out  4  ALU op code (IR[15:12] in EXEC, 4'b0100 otherwise)
- alu_a  out  DW  AC
- alu_b  out  DW  MDR
- alu_out  in  DW  ALU result
- alu_ban  in  1  ALU branch flag (AC[15] when alu_op=4'b1001)
- pc  out  AW  program counter
- ac  out  DW  accumulator
- halted  out  1  1 in HALT state
- instr_done  out  1  one-cycle pulse when an instruction retires
- step  in  1  single-step advance (present only with CPU_CTRL_SSTEP_EN)

## Operation
- Instruction format: IR[15:12] = op, IR[11:0] = address.
- Op codes:
  - 0000 CLA, 0001 COM, 0010 SHR, 0011 CSL, 0100 STP, 0101 ADD, 0110 STA, 0111 LDA, 1000 JMP, 1001 BAN.
  - 1010–1111 are executed as NOP.
- States: START, FETCH, DECODE, OPRD, EXEC, STORE, HALT.
- START:
  - Entered on reset.
  - Unconditionally goes to FETCH on the next edge.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ack: IR <= mem_rdata, pc <= pc+1 (mod 2^AW, 0xFFF wraps to 0x000), then go to DECODE.
- DECODE:
  - ADD/LDA go to OPRD.
  - STA goes to STORE.
  - STP goes to HALT.
  - All other ops go to EXEC.
- OPRD:
  - mem_req=1, mem_we=0, mem_addr=IR[11:0].
  - On ack: MDR <= mem_rdata, then go to EXEC.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=IR[11:0], mem_wdata=ac.
  - On ack: retire, then go to FETCH.
- EXEC:
  - alu_op=IR[15:12].
  - CLA, COM, SHR, CSL, ADD, LDA: AC <= alu_out.
  - JMP: pc <= IR[11:0].
  - BAN: pc <= IR[11:0] if alu_ban=1; otherwise pc is unchanged.
  - NOP: no register change.
  - Retire, then go to FETCH.
- HALT: terminal; only rst leaves it. instr_done pulses once on entry.
- Arithmetic: ADD wraps mod 2^16 (no carry kept); SHR is arithmetic (sign-preserving); CSL rotates left.
- mem_req deasserts in the cycle after ack (state has changed). mem_addr, mem_we and mem_wdata are stable while mem_req=1.

## Timing
- Reset values (asynchronous):
  - pc=0, ac=0, IR=0, MDR=0, state=START.
  - mem_req=0, mem_we=0, halted=0, instr_done=0, alu_op=4'b0100.
- Latency with zero-wait memory (ack in the same cycle as req), measured from entering FETCH:
  - CLA/COM/SHR/CSL/JMP/BAN/NOP: 3 cycles.
  - ADD/LDA: 4 cycles.
  - STA: 3 cycles.
  - STP: 2 cycles, then in HALT.
- Each wait cycle (mem_req=1, ack=0) adds exactly one cycle.
- instr_done is asserted in the cycle following the retiring edge, for exactly one cycle.
- Reset mid-operation (any state, including during an outstanding request) aborts immediately. mem_req drops asynchronously and no partial register update is committed.
- A spurious mem_ack while mem_req=0 is ignored.

## Configuration
- CPU_CTRL_SSTEP_EN defined:
  - Adds a PAUSE state and the step port.
  - After every retire, the controller enters PAUSE instead of FETCH.
  - A step=1 sample in PAUSE moves it to FETCH on the next edge.
  - step held high runs one instruction per instruction period.
  - After reset, START goes to PAUSE.
- CPU_CTRL_SSTEP_EN undefined: no PAUSE state and no step port; execution is free-running.

## Test plan
- Reset, memory {0:7005, 5:0003, 1:5005, 2:6006, 3:4000}, zero-wait ack:
  - Required: ac=0x0006 after ADD.
  - Write to address 6 with wdata 0x0006.
  - halted=1 at cycle 2 after fetch of address 3.
  - Exactly 4 instr_done pulses.
- ac=0x8001, execute SHR then CSL:
  - ac=0xC000 after SHR.
  - ac=0x8001 after CSL.
- BAN 0x020:
  - With ac=0x8000, pc becomes 0x020.
  - With ac=0x7FFF, pc becomes the fetched address + 1.
- mem_ack delayed 3 cycles on every request:
  - LDA takes 10 cycles.
  - mem_addr and mem_req stay stable during each wait.
- Assert rst while in OPRD with mem_req=1:
  - mem_req=0 and pc=0 immediately.
  - First fetch after release reads address 0.
- With CPU_CTRL_SSTEP_EN and step=0:
  - Controller stays in PAUSE with no mem_req.
  - A single step pulse yields exactly one instr_done.

Source files
------------

// File: rtl/cpu_ctrl.sv
// cpu_ctrl -- multi-cycle sequencer for the 16-bit accumulator machine.
//
// Fetches an instruction over a single-port memory handshake, decodes it,
// fetches an operand or stores AC when needed, and drives the external
// combinational ALU. Owns PC, IR, AC and MDR.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req/mem_we      memory request (held until mem_ack), write enable
//   mem_addr/mem_wdata  request address, write data (AC)
//   mem_rdata/mem_ack   read data and request completion
//   alu_op/alu_a/alu_b  ALU op code (IR op in EXEC, 4'b0100 otherwise), AC, MDR
//   alu_out/alu_ban     ALU result and branch flag
//   pc, ac              architectural registers
//   halted              high in HALT
//   instr_done          one-cycle pulse after an instruction retires
//   step                single-step advance (only with CPU_CTRL_SSTEP_EN)
//
// Build option: define CPU_CTRL_SSTEP_EN to add the PAUSE state and the step
// port; each retire then parks in PAUSE until step is sampled high.

module cpu_ctrl #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_ban,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ac,
  output logic          halted,
  output logic          instr_done
`ifdef CPU_CTRL_SSTEP_EN
  ,
  input  logic          step
`endif
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_OPRD,
    S_EXEC,
    S_STORE,
    S_HALT
`ifdef CPU_CTRL_SSTEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

`ifdef CPU_CTRL_SSTEP_EN
  localparam state_t S_AFTER = S_PAUSE;
`else
  localparam state_t S_AFTER = S_FETCH;
`endif

  localparam logic [3:0] OP_CLA = 4'h0;
  localparam logic [3:0] OP_COM = 4'h1;
  localparam logic [3:0] OP_SHR = 4'h2;
  localparam logic [3:0] OP_CSL = 4'h3;
  localparam logic [3:0] OP_STP = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BAN = 4'h9;
  localparam logic [3:0] OP_IDLE = 4'b0100;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ac_q, ac_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          halted_q, halted_d;
  logic          instr_done_q, instr_done_d;

  logic [3:0]    ir_op;
  logic          ack;
  logic          retire;

  assign ir_op = ir_q[DW-1:DW-4];
  // An ack only counts against a live request.
  assign ack   = mem_req_q & mem_ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    retire  = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_AFTER;
      end
      S_FETCH: begin
        if (ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_ADD, OP_LDA: state_d = S_OPRD;
          OP_STA:         state_d = S_STORE;
          OP_STP:         state_d = S_HALT;
          default:        state_d = S_EXEC;
        endcase
      end
      S_OPRD: begin
        if (ack) begin
          mdr_d   = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_STORE: begin
        if (ack) begin
          retire  = 1'b1;
          state_d = S_AFTER;
        end
      end
      S_EXEC: begin
        case (ir_op)
          OP_CLA, OP_COM, OP_SHR, OP_CSL, OP_ADD, OP_LDA: ac_d = alu_out;
          OP_JMP: pc_d = ir_q[AW-1:0];
          OP_BAN: if (alu_ban) pc_d = ir_q[AW-1:0];
          default: ;
        endcase
        retire  = 1'b1;
        state_d = S_AFTER;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`ifdef CPU_CTRL_SSTEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: begin
        state_d = S_START;
      end
    endcase

    // Outputs are registered, so they are derived from the state being
    // entered; this keeps them glitch-free and stable across wait cycles.
    mem_req_d    = (state_d == S_FETCH) || (state_d == S_OPRD) || (state_d == S_STORE);
    mem_we_d     = (state_d == S_STORE);
    mem_addr_d   = (state_d == S_FETCH) ? pc_d : ir_d[AW-1:0];
    alu_op_d     = (state_d == S_EXEC) ? ir_d[DW-1:DW-4] : OP_IDLE;
    halted_d     = (state_d == S_HALT);
    instr_done_d = retire || ((state_q == S_DECODE) && (state_d == S_HALT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_START;
      pc_q         <= '0;
      ac_q         <= '0;
      ir_q         <= '0;
      mdr_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      alu_op_q     <= OP_IDLE;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ac_q         <= ac_d;
      ir_q         <= ir_d;
      mdr_q        <= mdr_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      alu_op_q     <= alu_op_d;
      halted_q     <= halted_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = ac_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = ac_q;
  assign alu_b      = mdr_q;
  assign pc         = pc_q;
  assign ac         = ac_q;
  assign halted     = halted_q;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: memory responder with programmable wait states,
// external ALU, and an instruction-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_cpu_ctrl;

`ifdef CPU_CTRL_SSTEP_EN
  localparam int SS = 1;
`else
  localparam int SS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_ban;
  logic [11:0] pc;
  logic [15:0] ac;
  logic        halted, instr_done;
`ifdef CPU_CTRL_SSTEP_EN
  logic        step = 1'b1;
`endif

  cpu_ctrl #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_ban(alu_ban),
    .pc(pc), .ac(ac), .halted(halted), .instr_done(instr_done)
`ifdef CPU_CTRL_SSTEP_EN
    , .step(step)
`endif
  );

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    case (alu_op)
      4'h0:    alu_out = 16'h0000;
      4'h1:    alu_out = ~alu_a;
      4'h2:    alu_out = {alu_a[15], alu_a[15:1]};
      4'h3:    alu_out = {alu_a[14:0], alu_a[15]};
      4'h5:    alu_out = alu_a + alu_b;
      4'h7:    alu_out = alu_b;
      default: alu_out = alu_a;
    endcase
    alu_ban = (alu_op == 4'b1001) && alu_a[15];
  end

  // Memory
  logic [15:0] mem [0:4095];
  int wait_n = 0;
  int wcnt = 0;
  bit spur = 0;

  always @(posedge clk) begin
    #1;
    if (spur) begin
      mem_ack = 1'b1;
    end else if (mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
    mem_rdata = mem[mem_addr];
  end

  // Bookkeeping
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Instruction-level reference model
  logic [11:0] m_pc;
  logic [15:0] m_ac, m_ir, m_opnd;
  logic        m_halted;
  int          phase;      // 0 fetch pending, 1 operand read, 2 store, 3 no access left
  int          since, waits;
  logic        prev_wait, prev_we;
  logic [11:0] prev_addr;
  bit          chk_lat = 1;
  int          done_cnt, req_seen, cyc, fetch3_cyc, halt_cyc, wr_cnt;
  logic [15:0] done_ac [32];
  logic [11:0] done_pc [32];
  int          done_since [32];
  logic [11:0] first_fetch, wr_addr;
  logic [15:0] wr_data;
  bit          first_seen;
  logic [3:0]  c_op;
  logic [11:0] c_a;
  logic [15:0] c_word;

  function automatic int base_lat(input logic [3:0] op);
    if (op == 4'h5 || op == 4'h7) return 4;
    if (op == 4'h4) return 2;
    return 3;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_pc = '0; m_ac = '0; m_ir = '0; m_opnd = '0; m_halted = 1'b0;
      phase = 0; since = -1; waits = 0; prev_wait = 1'b0;
    end else begin
      cyc++;
      if (mem_req) req_seen++;
      if (prev_wait) begin
        chk("req_hold", mem_req, 1);
        chk("addr_hold", mem_addr, prev_addr);
        chk("we_hold", mem_we, prev_we);
      end
      if (instr_done) begin
        chk("done_phase", phase, 3);
        chk("done_after_halt", m_halted, 0);
        c_op = m_ir[15:12];
        c_a  = m_ir[11:0];
        case (c_op)
          4'h0: m_ac = 16'h0000;
          4'h1: m_ac = 16'hFFFF - m_ac;
          4'h2: m_ac = 16'($signed(m_ac) >>> 1);
          4'h3: m_ac = (m_ac << 1) | (m_ac >> 15);
          4'h4: m_halted = 1'b1;
          4'h5: m_ac = m_ac + m_opnd;
          4'h7: m_ac = m_opnd;
          4'h8: m_pc = c_a;
          4'h9: if (m_ac >= 16'h8000) m_pc = c_a;
          default: ;
        endcase
        if (chk_lat) chk("latency", since, base_lat(c_op) + waits + SS);
        chk("pc", pc, m_pc);
        chk("ac", ac, m_ac);
        if (done_cnt < 32) begin
          done_ac[done_cnt] = m_ac;
          done_pc[done_cnt] = m_pc;
          done_since[done_cnt] = since;
        end
        done_cnt++;
        since = 0; waits = 0; phase = 0;
      end
      chk("halted", halted, m_halted);
      if (alu_op != 4'b0100) chk("alu_op", alu_op, m_ir[15:12]);
      since++;
      if (mem_req && !mem_ack) waits++;
      if (mem_req && mem_ack) begin
        case (phase)
          0: begin
            chk("fetch_we", mem_we, 0);
            chk("fetch_addr", mem_addr, m_pc);
            if (!first_seen) begin first_fetch = mem_addr; first_seen = 1; end
            if (m_pc == 12'h003) fetch3_cyc = cyc;
            m_ir = mem[m_pc];
            m_pc = m_pc + 12'd1;
            c_op = m_ir[15:12];
            phase = (c_op == 4'h5 || c_op == 4'h7) ? 1 : (c_op == 4'h6) ? 2 : 3;
          end
          1: begin
            chk("oprd_we", mem_we, 0);
            chk("oprd_addr", mem_addr, m_ir[11:0]);
            m_opnd = mem[m_ir[11:0]];
            phase = 3;
          end
          2: begin
            chk("store_we", mem_we, 1);
            chk("store_addr", mem_addr, m_ir[11:0]);
            chk("store_data", mem_wdata, m_ac);
            mem[m_ir[11:0]] = m_ac;
            wr_addr = m_ir[11:0];
            wr_data = m_ac;
            wr_cnt++;
            phase = 3;
          end
          default: chk("extra_access", phase, 0);
        endcase
      end
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_we   = mem_we;
    end
  end

  // Stimulus helpers
  task automatic prep();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic go(input int wn);
    #2;
    chk("rst_pc", pc, 0);
    chk("rst_ac", ac, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_aluop", alu_op, 4'b0100);
    wait_n = wn; spur = 0;
    done_cnt = 0; first_seen = 0; fetch3_cyc = -1; halt_cyc = -1;
    wr_cnt = 0; req_seen = 0; cyc = 0;
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, halted, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit found;
    int n;

    // Program 1: LDA 5, ADD 5, STA 6, STP
    prep();
    mem[0] = 16'h7005; mem[1] = 16'h5005; mem[2] = 16'h6006; mem[3] = 16'h4000;
    mem[5] = 16'h0003;
    go(0);
    wait_halt(100, "p1_halt");
    chk("p1_done_cnt", done_cnt, 4);
    chk("p1_ac_add", done_ac[1], 16'h0006);
    chk("p1_wr_cnt", wr_cnt, 1);
    chk("p1_wr_addr", wr_addr, 12'h006);
    chk("p1_wr_data", wr_data, 16'h0006);
    chk("p1_halt_delay", halt_cyc - fetch3_cyc, 2);
    chk("p1_lat_lda", done_since[0], 4 + SS);
    chk("p1_lat_sta", done_since[2], 3 + SS);
    chk("p1_lat_stp", done_since[3], 2 + SS);
    spur = 1;
    repeat (5) @(negedge clk);
    spur = 0;
    chk("p1_spur_done", done_cnt, 4);
    chk("p1_spur_pc", pc, 12'h004);

    // Program 2: LDA 0x8001, SHR, CSL, STP
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h2000; mem[2] = 16'h3000; mem[3] = 16'h4000;
    mem[16] = 16'h8001;
    go(0);
    wait_halt(100, "p2_halt");
    chk("p2_shr", done_ac[1], 16'hC000);
    chk("p2_csl", done_ac[2], 16'h8001);

    // Program 3a: BAN taken
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h9020; mem[16] = 16'h8000; mem[32] = 16'h4000;
    go(0);
    wait_halt(100, "p3a_halt");
    chk("p3a_ban_pc", done_pc[1], 12'h020);

    // Program 3b: BAN not taken
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h9020; mem[2] = 16'h4000; mem[16] = 16'h7FFF;
    go(0);
    wait_halt(100, "p3b_halt");
    chk("p3b_ban_pc", done_pc[1], 12'h002);

    // Program 4: three wait states on every request
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h4000; mem[16] = 16'hABCD;
    go(3);
    wait_halt(200, "p4_halt");
    chk("p4_lat_lda", done_since[0], 10 + SS);
    chk("p4_lat_stp", done_since[1], 5 + SS);
    chk("p4_ac", done_ac[0], 16'hABCD);

    // Program 5: reset during an outstanding operand read
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h4000; mem[16] = 16'h1234;
    go(3);
    found = 0; n = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if (mem_req && !mem_we && mem_addr == 12'h010) found = 1;
    end
    chk("p5_reach_oprd", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("p5_req_drop", mem_req, 0);
    chk("p5_pc_zero", pc, 0);
    chk("p5_ac_zero", ac, 0);
    @(posedge clk);
    @(posedge clk);
    go(0);
    wait_halt(100, "p5_halt");
    chk("p5_first_fetch", first_fetch, 12'h000);
    chk("p5_ac", done_ac[0], 16'h1234);

    // Program 6: ADD wrap, COM, NOP, CLA, JMP, PC wrap, self-modifying STA
    prep();
    mem[0] = 16'h7010; mem[1] = 16'h5011; mem[2] = 16'h1000; mem[3] = 16'hA000;
    mem[4] = 16'h0000; mem[5] = 16'h7012; mem[6] = 16'h8FFE;
    mem[12'hFFE] = 16'hF000; mem[12'hFFF] = 16'h6000;
    mem[16] = 16'hFFFF; mem[17] = 16'h0002; mem[18] = 16'h4000;
    go(1);
    wait_halt(300, "p6_halt");
    chk("p6_done_cnt", done_cnt, 10);
    chk("p6_add_wrap", done_ac[1], 16'h0001);
    chk("p6_com", done_ac[2], 16'hFFFE);
    chk("p6_cla", done_ac[4], 16'h0000);
    chk("p6_jmp_pc", done_pc[6], 12'hFFE);
    chk("p6_pc_wrap", done_pc[8], 12'h000);
    chk("p6_wr_data", wr_data, 16'h4000);

`ifdef CPU_CTRL_SSTEP_EN
    // Single-step: parked in PAUSE until one step pulse
    prep();
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    step = 1'b0;
    chk_lat = 0;
    go(0);
    repeat (20) @(negedge clk);
    chk("ss_no_req", req_seen, 0);
    chk("ss_no_done", done_cnt, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (20) @(negedge clk);
    chk("ss_one_done", done_cnt, 1);
    step = 1'b1;
    chk_lat = 1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
